uart_tx: RTL

UART transmitter: the sending end of the team's serial link and the counterpart of `uart_rx`. It accepts a byte on a one-cycle strobe and serialises it on a single line, LSB first, in a frame of start bit, 8 data bits, even-parity bit and stop bit. This frame format and bit timing are the ones `uart_rx` captures, so the two blocks connect directly in loopback. It sits between the system-side byte producer and the physical TX pin.

---
 rtl/uart_tx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Serialises one byte per i_Tx_Dv strobe, LSB
// first, framed as start(0), D0..D7, [even parity], stop(1).
//
// Build option: define UART_TX_PARITY_EN to include the even-parity bit
// (11-bit frame). Leave it undefined for a 10-bit frame with no parity.
//
// Parameters:
//   CLK_CY_PER_BIT  clock cycles per serial bit (2..65535)
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_Tx_Dv      one-cycle strobe, i_Tx_Byte valid
//   i_Tx_Byte    byte to send
//   o_Tx_Serial  serial line, idles high
//   o_Tx_Active  high from start bit through stop bit
//   o_Tx_Done    one-cycle pulse after the stop bit
module uart_tx #(
  parameter int CLK_CY_PER_BIT = 87
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_Tx_Dv,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CLEANUP
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP
  } state_e;
`endif

  localparam logic [15:0] LastCnt = 16'(CLK_CY_PER_BIT - 1);

  state_e      state_q;
  logic [15:0] clk_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  byte_q;
`ifdef UART_TX_PARITY_EN
  logic        parity_q;
`endif
  logic        serial_q;
  logic        active_q;
  logic        done_q;

  logic bit_end;
  assign bit_end = (clk_cnt_q == LastCnt);

  // Outputs are registered: each transition loads the line value of the
  // bit being entered, so the line changes on the same edge as the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      byte_q    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // CLEANUP accepts a strobe exactly like IDLE, giving the
        // minimum N+1 stop-bit gap for back-to-back frames.
        S_IDLE, S_CLEANUP: begin
          serial_q  <= 1'b1;
          active_q  <= 1'b0;
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          state_q   <= S_IDLE;
          if (i_Tx_Dv) begin
            byte_q   <= i_Tx_Byte;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^i_Tx_Byte;
`endif
            serial_q <= 1'b0;
            active_q <= 1'b1;
            state_q  <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            serial_q  <= byte_q[0];
            state_q   <= S_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
              serial_q  <= parity_q;
              state_q   <= S_PARITY;
`else
              serial_q  <= 1'b1;
              state_q   <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              serial_q  <= byte_q[bit_idx_q + 3'd1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            serial_q  <= 1'b1;
            state_q   <= S_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_CLEANUP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        default: begin
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          serial_q  <= 1'b1;
          active_q  <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

endmodule
